// File: rtl/board_io_bridge.sv
// Registered bridge between the CPU's 32-bit IO words and the DE2 board pins:
// switch sync/debounce, per-digit 7-segment mode, and an HD44780 EN strobe engine.
module board_io_bridge #(
  parameter int NUM_SW        = 17,
  parameter int NUM_HEX       = 8,
  parameter int NUM_LEDR      = 17,
  parameter int NUM_LEDG      = 8,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int LCD_SETUP_CYC = 4,
  parameter int LCD_EN_CYC    = 12,
  parameter int LCD_HOLD_CYC  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_SW-1:0]      sw_raw_i,
  output logic [31:0]            io_sw_o,
  input  logic [31:0]            io_ledr_i,
  input  logic [31:0]            io_ledg_i,
  input  logic [32*NUM_HEX-1:0]  io_hex_i,
  input  logic [NUM_HEX-1:0]     hex_mode_i,
  input  logic [31:0]            io_lcd_i,
  output logic [NUM_LEDR-1:0]    ledr_o,
  output logic [NUM_LEDG-1:0]    ledg_o,
  output logic [7*NUM_HEX-1:0]   hex_o,
  output logic [7:0]             lcd_data_o,
  output logic                   lcd_rw_o,
  output logic                   lcd_rs_o,
  output logic                   lcd_en_o,
  output logic                   lcd_on_o,
  output logic                   lcd_busy_o,
  output logic                   err_o,
  output logic [1:0]             lcd_state_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  localparam logic [15:0] SETUP_LOAD = 16'(LCD_SETUP_CYC - 1);
  localparam logic [15:0] EN_LOAD    = 16'(LCD_EN_CYC - 1);
  localparam logic [15:0] HOLD_LOAD  = 16'(LCD_HOLD_CYC - 1);

  // Bits above the board width must be zero; a full 32-bit width leaves nothing to check.
  localparam logic [31:0] LEDR_UNUSED = (NUM_LEDR >= 32) ? 32'h0 : ~((32'h1 << NUM_LEDR) - 32'h1);
  localparam logic [31:0] LEDG_UNUSED = (NUM_LEDG >= 32) ? 32'h0 : ~((32'h1 << NUM_LEDG) - 32'h1);

  logic [NUM_SW-1:0]    r_sw_meta;
  logic [NUM_SW-1:0]    r_sw_sync;
  logic [NUM_SW-1:0]    r_sw_db;
  logic [DB_W-1:0]      r_db_cnt [NUM_SW];

  logic [NUM_LEDR-1:0]  r_ledr;
  logic [NUM_LEDG-1:0]  r_ledg;
  logic [7*NUM_HEX-1:0] r_hex;

  logic [1:0]           r_lcd_state;
  logic [15:0]          r_lcd_cnt;
  logic [7:0]           r_lcd_data;
  logic                 r_lcd_rw;
  logic                 r_lcd_rs;
  logic                 r_lcd_en;
  logic                 r_lcd_on;
  logic                 r_start_prev;
  logic                 r_err;

  logic                 w_start;
  logic                 w_start_drop;
  logic                 w_hex_bad;
  logic                 w_led_bad;
  logic                 w_lcd_bad;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // A bit that stays equal to its debounced value keeps the counter at zero, so any
  // return to the old level (a toggle) restarts the stability window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_db   <= '0;
      for (int i = 0; i < NUM_SW; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sw_meta <= sw_raw_i;
      r_sw_sync <= r_sw_meta;
      for (int i = 0; i < NUM_SW; i++) begin
        if (r_sw_sync[i] == r_sw_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_sw_db[i]  <= ~r_sw_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_hex  <= '1;
    end else begin
      r_ledr <= io_ledr_i[NUM_LEDR-1:0];
      r_ledg <= io_ledg_i[NUM_LEDG-1:0];
      for (int k = 0; k < NUM_HEX; k++) begin
        if (hex_mode_i[k]) r_hex[7*k +: 7] <= ~seg_decode(io_hex_i[32*k +: 4]);
        else               r_hex[7*k +: 7] <= ~io_hex_i[32*k +: 7];
      end
    end
  end

  always_comb begin
    w_hex_bad = 1'b0;
    for (int k = 0; k < NUM_HEX; k++) begin
      if (hex_mode_i[k]) w_hex_bad = w_hex_bad | (|(io_hex_i[32*k +: 32] & 32'hFFFF_FFF0));
      else               w_hex_bad = w_hex_bad | (|(io_hex_i[32*k +: 32] & 32'hFFFF_FF80));
    end
  end

  assign w_led_bad = (|(io_ledr_i & LEDR_UNUSED)) | (|(io_ledg_i & LEDG_UNUSED));
  assign w_lcd_bad = |io_lcd_i[30:11];

  // Handshake: a 0->1 on io_lcd_i[10] requests a strobe; it is accepted only while
  // lcd_busy_o=0 at that edge, otherwise it is dropped and flagged on err_o.
  assign w_start      = io_lcd_i[10] & ~r_start_prev;
  assign w_start_drop = w_start & (r_lcd_state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lcd_state  <= IDLE;
      r_lcd_cnt    <= '0;
      r_lcd_data   <= '0;
      r_lcd_rw     <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_en     <= 1'b0;
      r_lcd_on     <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= io_lcd_i[10];
      r_lcd_on     <= io_lcd_i[31];
      case (r_lcd_state)
        IDLE: begin
          if (w_start) begin
            r_lcd_data  <= io_lcd_i[7:0];
            r_lcd_rw    <= io_lcd_i[8];
            r_lcd_rs    <= io_lcd_i[9];
            r_lcd_cnt   <= SETUP_LOAD;
            r_lcd_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_lcd_cnt == 16'd0) begin
            r_lcd_en    <= 1'b1;
            r_lcd_cnt   <= EN_LOAD;
            r_lcd_state <= PULSE;
          end else begin
            r_lcd_cnt <= r_lcd_cnt - 16'd1;
          end
        end
        PULSE: begin
          if (r_lcd_cnt == 16'd0) begin
            r_lcd_en    <= 1'b0;
            r_lcd_cnt   <= HOLD_LOAD;
            r_lcd_state <= HOLD;
          end else begin
            r_lcd_cnt <= r_lcd_cnt - 16'd1;
          end
        end
        default: begin
          if (r_lcd_cnt == 16'd0) r_lcd_state <= IDLE;
          else                    r_lcd_cnt   <= r_lcd_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= r_err | w_led_bad | w_hex_bad | w_lcd_bad | w_start_drop;
  end

  assign io_sw_o     = 32'(r_sw_db);
  assign ledr_o      = r_ledr;
  assign ledg_o      = r_ledg;
  assign hex_o       = r_hex;
  assign lcd_data_o  = r_lcd_data;
  assign lcd_rw_o    = r_lcd_rw;
  assign lcd_rs_o    = r_lcd_rs;
  assign lcd_en_o    = r_lcd_en;
  assign lcd_on_o    = r_lcd_on;
  assign lcd_busy_o  = (r_lcd_state != IDLE);
  assign err_o       = r_err;
  assign lcd_state_o = r_lcd_state;

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge: reset, debounce, LEDs, hex modes, LCD strobe,
// overrun and reset-mid-strobe, with hand-computed expectations.
module tb_board_io_bridge;

  localparam int NUM_HEX = 8;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [16:0]           sw_raw_i;
  logic [31:0]           io_sw_o;
  logic [31:0]           io_ledr_i;
  logic [31:0]           io_ledg_i;
  logic [32*NUM_HEX-1:0] io_hex_i;
  logic [NUM_HEX-1:0]    hex_mode_i;
  logic [31:0]           io_lcd_i;
  logic [16:0]           ledr_o;
  logic [7:0]            ledg_o;
  logic [7*NUM_HEX-1:0]  hex_o;
  logic [7:0]            lcd_data_o;
  logic                  lcd_rw_o;
  logic                  lcd_rs_o;
  logic                  lcd_en_o;
  logic                  lcd_on_o;
  logic                  lcd_busy_o;
  logic                  err_o;
  logic [1:0]            lcd_state_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] exp_q[$];

  board_io_bridge dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sw_raw_i    (sw_raw_i),
    .io_sw_o     (io_sw_o),
    .io_ledr_i   (io_ledr_i),
    .io_ledg_i   (io_ledg_i),
    .io_hex_i    (io_hex_i),
    .hex_mode_i  (hex_mode_i),
    .io_lcd_i    (io_lcd_i),
    .ledr_o      (ledr_o),
    .ledg_o      (ledg_o),
    .hex_o       (hex_o),
    .lcd_data_o  (lcd_data_o),
    .lcd_rw_o    (lcd_rw_o),
    .lcd_rs_o    (lcd_rs_o),
    .lcd_en_o    (lcd_en_o),
    .lcd_on_o    (lcd_on_o),
    .lcd_busy_o  (lcd_busy_o),
    .err_o       (err_o),
    .lcd_state_o (lcd_state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else             n_pass++;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full strobe of data 8'h41 with RS=1: start edge seen at k=0.
  task automatic run_strobe(input string tag);
    io_lcd_i = 32'h0000_0241;
    step(1);
    io_lcd_i = 32'h0000_0641;
    step(1);
    for (int k = 0; k <= 20; k++) begin
      check({tag, "_en"},   64'(lcd_en_o),   64'((k >= 4 && k <= 15) ? 1 : 0));
      check({tag, "_busy"}, 64'(lcd_busy_o), 64'((k <= 19) ? 1 : 0));
      check({tag, "_bus"},  64'({lcd_data_o, lcd_rs_o, lcd_rw_o}), 64'({8'h41, 1'b1, 1'b0}));
      if (k == 0)  check({tag, "_st_setup"}, 64'(lcd_state_o), 64'd1);
      if (k == 4)  check({tag, "_st_pulse"}, 64'(lcd_state_o), 64'd2);
      if (k == 16) check({tag, "_st_hold"},  64'(lcd_state_o), 64'd3);
      if (k == 20) check({tag, "_st_idle"},  64'(lcd_state_o), 64'd0);
      if (k < 20) step(1);
    end
  endtask

  // Driver / stimulus
  initial begin
    logic       seen;
    logic [6:0] exp_v;
    logic [6:0] seg_lo [16];
    seg_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset with random inputs
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sw_raw_i   = 17'($urandom);
      io_ledr_i  = $urandom;
      io_ledg_i  = $urandom;
      for (int k = 0; k < NUM_HEX; k++) io_hex_i[32*k +: 32] = $urandom;
      hex_mode_i = 8'($urandom);
      io_lcd_i   = $urandom;
      step(1);
    end
    check("rst_hex",  64'(hex_o),       64'h00FF_FFFF_FFFF_FFFF);
    check("rst_sw",   64'(io_sw_o),     64'h0);
    check("rst_en",   64'(lcd_en_o),    64'h0);
    check("rst_err",  64'(err_o),       64'h0);
    check("rst_busy", 64'(lcd_busy_o),  64'h0);
    check("rst_ledr", 64'(ledr_o),      64'h0);
    check("rst_st",   64'(lcd_state_o), 64'h0);

    sw_raw_i = '0; io_ledr_i = '0; io_ledg_i = '0;
    io_hex_i = '0; hex_mode_i = '0; io_lcd_i = '0;
    rst_i = 1'b0;
    step(2);

    // Debounce: 10-cycle glitch never reaches io_sw_o
    sw_raw_i[0] = 1'b1;
    step(10);
    sw_raw_i[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      seen = seen | io_sw_o[0];
    end
    check("sw_glitch", 64'(seen), 64'h0);

    // Debounce: clean edge appears exactly 18 cycles later
    sw_raw_i[0] = 1'b1;
    step(17);
    check("sw_edge_17", 64'(io_sw_o), 64'h0);
    step(1);
    check("sw_edge_18", 64'(io_sw_o), 64'h1);

    // LEDs
    io_ledr_i = 32'h0001_5A5A;
    io_ledg_i = 32'h0000_00A5;
    step(1);
    check("ledr", 64'(ledr_o), 64'h1_5A5A);
    check("ledg", 64'(ledg_o), 64'hA5);

    // Hex digit 0 decode then raw
    hex_mode_i[0] = 1'b1;
    io_hex_i[31:0] = 32'hA;
    step(1);
    check("hex_dec_A", 64'(hex_o[6:0]), 64'h08);
    hex_mode_i[0] = 1'b0;
    io_hex_i[31:0] = 32'h3F;
    step(1);
    check("hex_raw_3F", 64'(hex_o[6:0]), 64'h40);

    // Digit 7 raw, digit 3 decode sweep
    io_hex_i[32*7 +: 32] = 32'h55;
    hex_mode_i[3] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      io_hex_i[32*3 +: 32] = 32'(n);
      exp_q.push_back(seg_lo[n]);
      step(1);
      exp_v = exp_q.pop_front();
      check("hex_sweep", 64'(hex_o[27:21]), 64'(exp_v));
    end
    check("hex_raw_d7", 64'(hex_o[55:49]), 64'h2A);
    check("err_clean",  64'(err_o),        64'h0);

    // LCD power bit
    io_lcd_i = 32'h8000_0000;
    step(1);
    check("lcd_on", 64'(lcd_on_o), 64'h1);
    io_lcd_i = 32'h0;
    step(1);
    check("lcd_off", 64'(lcd_on_o), 64'h0);

    // LCD strobe
    run_strobe("strobe");
    check("strobe_err", 64'(err_o), 64'h0);

    // Hex misuse flag is sticky
    io_hex_i[31:0] = 32'h80;
    step(1);
    check("err_hex", 64'(err_o), 64'h1);
    io_hex_i[31:0] = 32'h0;
    step(3);
    check("err_sticky", 64'(err_o), 64'h1);

    rst_i = 1'b1;
    io_lcd_i = 32'h0;
    step(1);
    rst_i = 1'b0;
    check("err_cleared", 64'(err_o), 64'h0);

    // Overrun: second start during PULSE
    io_lcd_i = 32'h0000_0241;
    step(1);
    io_lcd_i = 32'h0000_0641;
    step(1);
    step(5);
    check("ovr_in_pulse", 64'(lcd_en_o), 64'h1);
    io_lcd_i = 32'h0000_0241;
    step(1);
    io_lcd_i = 32'h0000_0641;
    step(1);
    check("ovr_err", 64'(err_o), 64'h1);
    step(13);
    check("ovr_busy_end", 64'(lcd_busy_o), 64'h0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      seen = seen | lcd_en_o;
    end
    check("ovr_no_pulse", 64'(seen), 64'h0);
    check("ovr_err_hold", 64'(err_o), 64'h1);

    // Reset mid-PULSE
    rst_i = 1'b1;
    io_lcd_i = 32'h0;
    step(1);
    rst_i = 1'b0;
    io_lcd_i = 32'h0000_0241;
    step(1);
    io_lcd_i = 32'h0000_0641;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1);
      seen = lcd_en_o;
    end
    check("mid_en_seen", 64'(seen), 64'h1);
    rst_i = 1'b1;
    io_lcd_i = 32'h0000_0241;
    step(1);
    check("mid_rst_en",   64'(lcd_en_o),    64'h0);
    check("mid_rst_busy", 64'(lcd_busy_o),  64'h0);
    check("mid_rst_st",   64'(lcd_state_o), 64'h0);
    rst_i = 1'b0;
    step(1);
    run_strobe("restrobe");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
